mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory stage of the pipelined CPU. Consumes the EX/MEM bundle: ALU result as address/data, store data, memory length/write-enable, and register-write controls.
- Performs loads and stores over a req/ack data-memory bus with byte-lane alignment and load sign/zero extension.
- Stalls the pipeline while an access is outstanding.
- Produces the registered write-back bundle and a combinational forwarding bundle for hazard resolution.

Parameters:
- TIMEOUT, 16: cycles to wait for dm_ack before aborting with bus error; 0 disables the timeout.
- AW, 32: data-memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM bundle valid this cycle.
- regwe_i  in  1  register write enable.
- cregwd_i  in  2  write-data select: CWD_ALU=0, CWD_MEM=1.
- wa_i  in  5  resolved destination register.
- memlen_i  in  3  access kind: ML_NONE=0, ML_SB=1 (signed byte), ML_UB=2, ML_SH=3 (signed half), ML_UH=4, ML_W=5.
- memwe_i  in  1  1 = store, 0 = load.
- aluout_i  in  32  address, or ALU result.
- rd2_i  in  32  store data.
- stall_o  out  1  freeze upstream stages.
- dm_req  out  1  bus request.
- dm_we  out  1  bus write.
- dm_addr  out  AW  word-aligned address.
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-replicated store data.
- dm_ack  in  1  bus completion.
- dm_rdata  in  32  read data.
- wb_valid  out  1  write-back bundle valid.
- wb_we  out  1  write-back register write enable.
- wb_wa  out  5  write-back destination register.
- wb_wd  out  32  write-back data.
- fwd_we  out  1  forwarding write enable.
- fwd_wa  out  5  forwarding destination register.
- fwd_wd  out  32  forwarding data.
- exc_o  out  2  one-cycle pulse: 01 misaligned, 10 bus timeout.

Behaviour:
- Reset (rst=0, async): state=IDLE. dm_req, dm_we, dm_be, wb_valid, wb_we, exc_o all 0; dm_addr, dm_wdata, wb_wa, wb_wd all 0.
- States: IDLE, BUSY, RESP.
- IDLE, in_valid, memlen_i=ML_NONE:
  - Bundle registered to wb_* next cycle (latency 1).
  - wb_wd = aluout_i when cregwd_i=CWD_ALU, else 0.
  - No stall.
- IDLE, in_valid, memory op, misaligned (half with addr[0]=1; word with addr[1:0]≠0):
  - Access suppressed; exc_o=01 next cycle.
  - wb_valid=1 with wb_we=0. No stall.
- IDLE, in_valid, memory op, aligned:
  - stall_o=1 combinationally.
  - Next cycle: BUSY with dm_req=1, dm_addr={aluout[AW-1:2],2'b00}, dm_we=memwe_i.
  - Byte: dm_be=1<<addr[1:0], dm_wdata={4{rd2[7:0]}}.
  - Half: dm_be=addr[1]?1100:0011, dm_wdata={2{rd2[15:0]}}.
  - Word: dm_be=1111, dm_wdata=rd2.
  - Controls (wa, regwe, memlen, addr[1:0]) latched.
- BUSY:
  - dm_req and all bus outputs held stable until the dm_ack cycle.
  - stall_o=1 while !dm_ack; stall_o=0 in the ack cycle so the pipeline advances.
  - On ack: dm_req=0 next cycle.
  - Load: select lane by latched addr[1:0], sign- or zero-extend per memlen, register into wb_wd.
  - Store: wb_we=0.
  - wb_valid=1 next cycle; state→IDLE. (RESP is the one-cycle state presenting wb_* and is simultaneously able to accept a new bundle, so back-to-back accesses cost 2 cycles + bus latency.)
- Timeout: after TIMEOUT cycles in BUSY without dm_ack:
  - dm_req drops; exc_o=10 pulse; wb_valid=1, wb_we=0.
  - state→IDLE; stall released in the same cycle the abort is decided.
- dm_ack outside BUSY: ignored.
- wb_valid: single-cycle pulse per accepted bundle.
- Forwarding bundle:
  - fwd_* reflects the bundle currently held in this stage (IDLE input, or latched op in BUSY).
  - fwd_we=0 for loads until data is registered, which forces a load-use stall in hazard logic.
  - For ALU ops: fwd_wd=aluout_i.
- Reset mid-access: dm_req drops immediately (async); the outstanding transaction is abandoned; a later stray ack is ignored.

Decomposition:
- Shared macro header holds:
  - ML_* and CWD_* encodings.
  - State encodings.
  - Exception codes.
- One natural sub-module, load_align: combinational lane select plus sign/zero extension from (rdata, addr[1:0], memlen).
- Store byte-enable generation stays inline.

Test Plan:
- ALU op: in_valid, memlen=0, cregwd=ALU, aluout=0x1234, wa=5 → next cycle wb_valid=1, wb_we=1, wb_wa=5, wb_wd=0x1234; stall_o never 1.
- SB: addr=0x103, rd2=0xAB → dm_be=1000, dm_wdata=0xABABABAB, dm_addr=0x100. Ack after 3 cycles → stall_o high exactly 3 cycles, wb_we=0.
- LB signed: addr=0x101, rdata=0x0000_8000 → wb_wd=0xFFFFFF80. LHU at addr 0x2 with rdata=0xF00D_0000 → wb_wd=0x0000F00D.
- LW at addr 0x6 → no dm_req, exc_o=01 one cycle, wb_we=0.
- TIMEOUT=4, no ack → dm_req high 4 cycles then drops, exc_o=10, stall released. A late ack is ignored.
- Assert rst low while BUSY → dm_req=0 and wb_valid=0 immediately. After release, a new LW at 0x10 with rdata=0xDEADBEEF completes correctly.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory stage: access kinds, write-data select,
// FSM states, exception codes and the latched in-flight op.
package mem_access_unit_pkg;

  localparam logic [2:0] ML_NONE = 3'd0;
  localparam logic [2:0] ML_SB   = 3'd1;
  localparam logic [2:0] ML_UB   = 3'd2;
  localparam logic [2:0] ML_SH   = 3'd3;
  localparam logic [2:0] ML_UH   = 3'd4;
  localparam logic [2:0] ML_W    = 3'd5;

  localparam logic [1:0] CWD_ALU = 2'd0;
  localparam logic [1:0] CWD_MEM = 2'd1;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_MISAL   = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic       regwe;
    logic [4:0] wa;
    logic [2:0] memlen;
    logic [1:0] off;
    logic       we;
  } mem_op_t;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: picks the addressed lane of a read word and sign/zero
// extends it. Ports: rdata, off (byte offset), memlen in; data out.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  memlen,
  output logic [31:0] data
);

  logic [31:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    data = sh;
    unique case (1'b1)
      memlen == ML_SB: data = {{24{sh[7]}}, sh[7:0]};
      memlen == ML_UB: data = {24'h0, sh[7:0]};
      memlen == ML_SH: data = {{16{sh[15]}}, sh[15:0]};
      memlen == ML_UH: data = {16'h0, sh[15:0]};
      default:         data = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage. EX/MEM bundle in; req/ack data bus
// (dm_*) out; registered wb_* and combinational fwd_* out; stall_o, exc_o.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          regwe_i,
  input  logic [1:0]    cregwd_i,
  input  logic [4:0]    wa_i,
  input  logic [2:0]    memlen_i,
  input  logic          memwe_i,
  input  logic [31:0]   aluout_i,
  input  logic [31:0]   rd2_i,
  output logic          stall_o,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_wdata,
  input  logic          dm_ack,
  input  logic [31:0]   dm_rdata,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [4:0]    wb_wa,
  output logic [31:0]   wb_wd,
  output logic          fwd_we,
  output logic [4:0]    fwd_wa,
  output logic [31:0]   fwd_wd,
  output logic [1:0]    exc_o
);

  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_t      state, state_nx;
  mem_op_t     op_q;
  logic [15:0] cnt_q;

  logic        is_mem, is_byte, is_half, is_word;
  logic        misal, take, go, busy, acked, abort;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx, ld_data;

  assign is_byte = (memlen_i == ML_SB) || (memlen_i == ML_UB);
  assign is_half = (memlen_i == ML_SH) || (memlen_i == ML_UH);
  assign is_word = (memlen_i == ML_W);
  assign is_mem  = is_byte || is_half || is_word;
  assign misal   = (is_half && aluout_i[0])
                || (is_word && (aluout_i[1:0] != 2'b00));

  // RESP accepts like IDLE, so only BUSY blocks new bundles.
  assign busy  = (state == ST_BUSY);
  assign take  = in_valid && !busy;
  assign go    = take && is_mem && !misal;
  assign acked = busy && dm_ack;
  assign abort = busy && !dm_ack && (TIMEOUT != 0)
              && (cnt_q == TO_LAST);

  assign stall_o = go || (busy && !dm_ack && !abort);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_RESP: state_nx = go ? ST_BUSY : ST_IDLE;
      ST_BUSY: begin
        if (acked)      state_nx = ST_RESP;
        else if (abort) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = rd2_i;
    unique case (1'b1)
      is_byte: begin
        be_nx    = 4'b0001 << aluout_i[1:0];
        wdata_nx = {4{rd2_i[7:0]}};
      end
      is_half: begin
        be_nx    = aluout_i[1] ? 4'b1100 : 4'b0011;
        wdata_nx = {2{rd2_i[15:0]}};
      end
      default: ;
    endcase
  end

  load_align u_align (
    .rdata  (dm_rdata),
    .off    (op_q.off),
    .memlen (op_q.memlen),
    .data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= '0;
      dm_wdata <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_wa    <= '0;
      wb_wd    <= '0;
      exc_o    <= EXC_NONE;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      exc_o    <= EXC_NONE;
      if (take) begin
        wb_wa <= wa_i;
        if (go) begin
          dm_req   <= 1'b1;
          dm_we    <= memwe_i;
          dm_addr  <= {aluout_i[AW-1:2], 2'b00};
          dm_be    <= be_nx;
          dm_wdata <= wdata_nx;
          cnt_q    <= '0;
          op_q     <= '{regwe:  regwe_i,
                        wa:     wa_i,
                        memlen: memlen_i,
                        off:    aluout_i[1:0],
                        we:     memwe_i};
        end else begin
          wb_valid <= 1'b1;
          wb_we    <= regwe_i && !is_mem;
          wb_wd    <= (!is_mem && cregwd_i == CWD_ALU)
                      ? aluout_i : '0;
          if (is_mem) exc_o <= EXC_MISAL;
        end
      end
      if (busy) begin
        cnt_q <= cnt_q + 16'd1;
        if (acked || abort) begin
          dm_req   <= 1'b0;
          dm_we    <= 1'b0;
          dm_be    <= '0;
          wb_valid <= 1'b1;
          wb_wa    <= op_q.wa;
          wb_we    <= acked && op_q.regwe && !op_q.we;
          wb_wd    <= (acked && !op_q.we) ? ld_data : '0;
          if (abort) exc_o <= EXC_TIMEOUT;
        end
      end
    end
  end

  // Loads never forward: hazard logic must stall until wb_* holds data.
  always_comb begin
    fwd_we = 1'b0;
    fwd_wa = wa_i;
    fwd_wd = aluout_i;
    if (busy) begin
      fwd_wa = op_q.wa;
      fwd_wd = '0;
    end else if (in_valid && !is_mem) begin
      fwd_we = regwe_i;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a transaction-level
// reference model, a per-cycle compare process and directed anchors.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int T = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        regwe_i = 0;
  logic [1:0]  cregwd_i = 0;
  logic [4:0]  wa_i = 0;
  logic [2:0]  memlen_i = 0;
  logic        memwe_i = 0;
  logic [31:0] aluout_i = 0;
  logic [31:0] rd2_i = 0;
  logic        dm_ack = 0;
  logic [31:0] dm_rdata = 0;
  logic        stall_o, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        wb_valid, wb_we, fwd_we;
  logic [4:0]  wb_wa, fwd_wa;
  logic [31:0] wb_wd, fwd_wd;
  logic [1:0]  exc_o;

  mem_access_unit #(.TIMEOUT(T), .AW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .regwe_i(regwe_i), .cregwd_i(cregwd_i), .wa_i(wa_i),
    .memlen_i(memlen_i), .memwe_i(memwe_i),
    .aluout_i(aluout_i), .rd2_i(rd2_i),
    .stall_o(stall_o), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_wa(wb_wa),
    .wb_wd(wb_wd), .fwd_we(fwd_we), .fwd_wa(fwd_wa),
    .fwd_wd(fwd_wd), .exc_o(exc_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          cwd;
    logic [1:0]  exc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] e_addr, e_wdata, s_addr, s_wdata;
  logic [3:0]  e_be, s_be;
  logic        e_we;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, want,
               $time);
    end
  endtask

  function automatic logic [31:0] ld_ref(input logic [31:0] rd,
                                         input logic [31:0] a,
                                         input logic [2:0] ml);
    logic [31:0] v, b, h;
    v = rd >> (8 * (a % 4));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (ml)
      ML_SB:   return (b >= 128) ? b - 256 : b;
      ML_UB:   return b;
      ML_SH:   return (h >= 32768) ? h - 65536 : h;
      ML_UH:   return h;
      default: return rd;
    endcase
  endfunction

  initial begin : cmp
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (wb_valid) begin
          if (exp_q.size() == 0) begin
            chk("wb_spurious", wb_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("wb_we", wb_we, e.we);
            chk("wb_wa", wb_wa, e.wa);
            if (e.cwd) chk("wb_wd", wb_wd, e.wd);
            chk("exc", exc_o, e.exc);
          end
        end else begin
          chk("exc_idle", exc_o, EXC_NONE);
        end
        if (dm_req) begin
          s_addr = dm_addr; s_be = dm_be; s_wdata = dm_wdata;
          chk("dm_addr", dm_addr, e_addr);
          chk("dm_be", dm_be, e_be);
          chk("dm_wdata", dm_wdata, e_wdata);
          chk("dm_we", dm_we, e_we);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge where wb_* is shown.
  // lat: BUSY cycle in which dm_ack is raised (out of 1..T = none).
  task automatic run_op(input logic rwe, input logic [1:0] cwd,
                        input logic [4:0] wa, input logic [2:0] ml,
                        input logic mwe, input logic [31:0] a,
                        input logic [31:0] d, input int lat,
                        input logic [31:0] rdata,
                        output int stalls);
    int  sz, reqs, want;
    bit  mem, mis, tmo, done;
    exp_t e;
    mem  = (ml >= ML_SB) && (ml <= ML_W);
    sz   = (ml == ML_W) ? 4 : (ml >= ML_SH) ? 2 : 1;
    mis  = mem && ((a % 32'(sz)) != 0);
    tmo  = mem && !mis && !(lat >= 1 && lat <= T);
    want = (!mem || mis) ? 0 : (tmo ? T : lat);
    e_we    = mwe;
    e_addr  = a & ~32'h3;
    e_be    = (sz == 4) ? 4'hF :
              (sz == 2) ? 4'(3 << (a % 4)) : 4'(1 << (a % 4));
    e_wdata = (sz == 4) ? d :
              (sz == 2) ? (d & 32'hFFFF) * 32'h0001_0001
                        : (d & 32'hFF) * 32'h0101_0101;
    in_valid = 1; regwe_i = rwe; cregwd_i = cwd; wa_i = wa;
    memlen_i = ml; memwe_i = mwe; aluout_i = a; rd2_i = d;
    stalls = 0; reqs = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      dm_ack = 0;
      dm_rdata = $urandom;
      if (dm_req) begin
        reqs++;
        chk("fwd_busy", fwd_we, 0);
        if (reqs == lat) begin
          dm_ack = 1;
          dm_rdata = rdata;
        end
      end
      #1;
      if (!stall_o) done = 1;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (!done) chk("hang", stall_o, 0);
    chk("stall_cnt", stalls, want);
    chk("req_cnt", reqs, want);
    chk("fwd_we", fwd_we, mem ? 1'b0 : rwe);
    chk("fwd_wa", fwd_wa, wa);
    if (!mem) chk("fwd_wd", fwd_wd, a);
    e.wa  = wa;
    e.exc = mis ? EXC_MISAL : tmo ? EXC_TIMEOUT : EXC_NONE;
    e.we  = !mem ? rwe : (mis || tmo || mwe) ? 1'b0 : rwe;
    e.wd  = !mem ? ((cwd == CWD_ALU) ? a : 32'h0)
                 : ld_ref(rdata, a, ml);
    e.cwd = !mem || e.we;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 0;
    dm_ack = 0;
  endtask

  initial begin : main
    int st;
    logic [31:0] a;
    logic [2:0]  ml;
    #2 rst = 0;
    #2;
    chk("rst_req", dm_req, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_be", dm_be, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wbwe", wb_we, 0);
    chk("rst_wbwa", wb_wa, 0);
    chk("rst_wbwd", wb_wd, 0);
    chk("rst_exc", exc_o, 0);
    repeat (2) @(negedge clk);
    rst = 1;

    run_op(1, CWD_ALU, 5, ML_NONE, 0, 32'h1234, 0, 0, 0, st);
    chk("alu_v", wb_valid, 1);
    chk("alu_wa", wb_wa, 5);
    chk("alu_wd", wb_wd, 32'h1234);

    run_op(0, CWD_ALU, 0, ML_SB, 1, 32'h103, 32'hAB, 3, 0, st);
    chk("sb_stall", st, 3);
    chk("sb_be", s_be, 4'b1000);
    chk("sb_wdata", s_wdata, 32'hABAB_ABAB);
    chk("sb_addr", s_addr, 32'h100);
    chk("sb_wbwe", wb_we, 0);

    run_op(1, CWD_MEM, 7, ML_SB, 0, 32'h101, 0, 1,
           32'h0000_8000, st);
    chk("lb_wd", wb_wd, 32'hFFFF_FF80);

    run_op(1, CWD_MEM, 8, ML_UH, 0, 32'h2, 0, 2,
           32'hF00D_0000, st);
    chk("lhu_wd", wb_wd, 32'h0000_F00D);

    run_op(1, CWD_MEM, 9, ML_W, 0, 32'h6, 0, 1, 0, st);
    chk("mis_exc", exc_o, EXC_MISAL);
    chk("mis_wbwe", wb_we, 0);

    run_op(1, CWD_MEM, 10, ML_W, 0, 32'h40, 0, 0, 0, st);
    chk("tmo_stall", st, T);
    chk("tmo_exc", exc_o, EXC_TIMEOUT);
    chk("tmo_wbwe", wb_we, 0);
    dm_ack = 1;
    @(negedge clk);
    dm_ack = 0;
    chk("stray_wbv", wb_valid, 0);
    chk("stray_req", dm_req, 0);

    e_we = 0; e_addr = 32'h20; e_be = 4'hF; e_wdata = 32'h55;
    in_valid = 1; regwe_i = 1; cregwd_i = CWD_MEM; wa_i = 3;
    memlen_i = ML_W; memwe_i = 0; aluout_i = 32'h20;
    rd2_i = 32'h55;
    @(negedge clk);
    chk("pre_rst_req", dm_req, 1);
    rst = 0;
    #1;
    chk("arst_req", dm_req, 0);
    chk("arst_wbv", wb_valid, 0);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    dm_ack = 1;
    @(negedge clk);
    dm_ack = 0;
    chk("post_rst_wbv", wb_valid, 0);

    run_op(1, CWD_MEM, 11, ML_W, 0, 32'h10, 0, 2,
           32'hDEAD_BEEF, st);
    chk("lw_wd", wb_wd, 32'hDEAD_BEEF);

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ml = 3'($urandom_range(0, 5));
      a = $urandom;
      if ($urandom_range(0, 2) != 0 && ml >= ML_SH)
        a = a & ~32'h3;
      run_op(1'($urandom), 2'($urandom_range(0, 1)),
             5'($urandom), ml, 1'($urandom), a, $urandom,
             $urandom_range(0, 6), $urandom, st);
    end

    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
